// File: rtl/arcade_input_router_pkg.sv
// Shared constants, enums and the external-pad remap for the arcade input router.
// Routed word layout: CO S2 S1 F2 F1 U D L R in [8:0].
package arcade_input_router_pkg;

    localparam int BTN_R    = 0;
    localparam int BTN_L    = 1;
    localparam int BTN_D    = 2;
    localparam int BTN_U    = 3;
    localparam int BTN_F1   = 4;
    localparam int BTN_F2   = 5;
    localparam int BTN_S1   = 6;
    localparam int BTN_S2   = 7;
    localparam int BTN_COIN = 8;

    // Raw DB9MD / DB15 indices: bit 9 is Z (DB9MD) or F (DB15), bit 11 is MODE or LS.
    localparam int DB_B      = 5;
    localparam int DB_C      = 6;
    localparam int DB_AUX    = 9;
    localparam int DB_START  = 10;
    localparam int DB_SELECT = 11;

    typedef enum logic [1:0] {
        SRC_USB   = 2'd0,
        SRC_DB9MD = 2'd1,
        SRC_DB15  = 2'd2
    } src_e;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } settle_e;

    function automatic logic [15:0] remap_ext(input logic [15:0] raw, input logic pad1);
        logic [15:0] r;
        r      = 16'h0000;
        r[5:0] = raw[5:0];
        if (pad1) begin
            r[BTN_S1] = raw[DB_AUX];
            r[BTN_S2] = raw[DB_START];
        end else begin
            r[BTN_S1] = raw[DB_START];
            r[BTN_S2] = raw[DB_AUX];
        end
        // START+B doubles as coin for pads without a dedicated coin button.
        r[BTN_COIN] = raw[DB_SELECT] | (raw[DB_START] & raw[DB_B]);
        return r;
    endfunction

endpackage

// File: rtl/arcade_input_router_if.sv
// Pad-side and core-side signal bundle of the arcade input router.
interface arcade_input_router_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int BTN_W       = 16
);
    logic [2:0]                   joy_mode;
    logic [NUM_PLAYERS*BTN_W-1:0] usb_joy;
    logic [31:0]                  db9md_joy;
    logic [31:0]                  db15_joy;
    logic                         cocktail;
    logic                         p2_active;
    logic [NUM_PLAYERS*BTN_W-1:0] joy;
    logic [BTN_W-1:0]             joy_game;
    logic [NUM_PLAYERS-1:0]       coin_pulse;
    logic                         osd_req;

    modport master (
        output joy_mode, usb_joy, db9md_joy, db15_joy, cocktail, p2_active,
        input  joy, joy_game, coin_pulse, osd_req
    );

    modport slave (
        input  joy_mode, usb_joy, db9md_joy, db15_joy, cocktail, p2_active,
        output joy, joy_game, coin_pulse, osd_req
    );
endinterface

// File: rtl/arcade_input_router_coin_shaper.sv
// One-shot coin pulse of exactly COIN_CYC cycles on a rising coin edge seen while idle.
module coin_shaper #(
    parameter int COIN_CYC = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic coin_in,
    output logic pulse
);
    localparam int CNT_W = $clog2(COIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             prev_q, prev_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Edges arriving while a pulse is running are swallowed; prev still tracks the input.
    always_comb begin
        prev_d = coin_in;
        cnt_d  = cnt_q;
        if (clr) begin
            prev_d = 1'b0;
            cnt_d  = CNT_ZERO;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (coin_in && !prev_q) begin
            cnt_d = CNT_LOAD;
        end else begin
            cnt_d = CNT_ZERO;
        end
        pulse_d = (cnt_d != CNT_ZERO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_router.sv
// Per-slot pad source select and remap, settle blanking after mode changes,
// merged/cocktail control word, coin shaping and OSD combo detection.
module arcade_input_router
    import arcade_input_router_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int BTN_W       = 16,
    parameter int SETTLE_CYC  = 1024,
    parameter int COIN_CYC    = 8192,
    parameter int OSD_CYC     = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    arcade_input_router_if.slave  bus
);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int OSD_W    = $clog2(OSD_CYC + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
    localparam logic [OSD_W-1:0]    OSD_MAX     = OSD_W'(OSD_CYC);
    localparam logic [OSD_W-1:0]    OSD_ONE     = OSD_W'(1);
    localparam logic [OSD_W-1:0]    OSD_ZERO    = {OSD_W{1'b0}};
    localparam logic [BTN_W-1:0]    BTN_ZERO    = {BTN_W{1'b0}};

    src_e                         src_s;
    logic [31:0]                  ext_s;
    int                           ext_cnt_s;
    logic [BTN_W-1:0]             ext_pad_s [2];
    logic [BTN_W-1:0]             routed_s  [NUM_PLAYERS];
    logic [BTN_W-1:0]             or_s;
    logic [BTN_W-1:0]             sel_s;
    logic                         mode_chg_s;
    logic                         run_s;
    logic                         combo_s;
    logic                         clr_s;
    logic [NUM_PLAYERS-1:0]       coin_s;

    settle_e                      state_q, state_d;
    logic [SETTLE_W-1:0]          settle_cnt_q, settle_cnt_d;
    logic [2:0]                   mode_q;
    logic [NUM_PLAYERS*BTN_W-1:0] joy_q, joy_d;
    logic [BTN_W-1:0]             game_q, game_d;
    logic [OSD_W-1:0]             osd_cnt_q, osd_cnt_d;
    logic                         osd_req_q, osd_req_d;

    // DB9MD wins over DB15; joy_mode[0] decides whether one or two external pads are in use.
    always_comb begin
        if (bus.joy_mode[2]) begin
            src_s = SRC_DB9MD;
        end else if (bus.joy_mode[1]) begin
            src_s = SRC_DB15;
        end else begin
            src_s = SRC_USB;
        end
        case (src_s)
            SRC_DB9MD: ext_s = bus.db9md_joy;
            SRC_DB15:  ext_s = bus.db15_joy;
            default:   ext_s = 32'h0000_0000;
        endcase
        if (src_s == SRC_USB) begin
            ext_cnt_s = 0;
        end else if (bus.joy_mode[0]) begin
            ext_cnt_s = 2;
        end else begin
            ext_cnt_s = 1;
        end
        ext_pad_s[0] = BTN_W'(remap_ext(ext_s[15:0], 1'b0));
        ext_pad_s[1] = BTN_W'(remap_ext(ext_s[31:16], 1'b1));
    end

    // External pads occupy the first slots; USB pads shift up behind them.
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            routed_s[i] = BTN_ZERO;
            if (i < ext_cnt_s) begin
                routed_s[i] = ext_pad_s[i[0]];
            end else if ((i - ext_cnt_s) < NUM_PLAYERS) begin
                routed_s[i] = bus.usb_joy[(i - ext_cnt_s)*BTN_W +: BTN_W];
            end else begin
                routed_s[i] = BTN_ZERO;
            end
        end
    end

    assign mode_chg_s = (bus.joy_mode != mode_q);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        if (mode_chg_s) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_ZERO) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SETTLE_ONE;
                    end
                end
                ST_RUN: state_d = ST_RUN;
                default: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end
            endcase
        end
    end

    assign run_s = (state_q == ST_RUN) && !mode_chg_s;
    assign clr_s = (state_q == ST_SETTLE) || mode_chg_s;

    // In cocktail mode coin/start stay shared so either player can insert coins or start.
    always_comb begin
        or_s = BTN_ZERO;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            or_s = or_s | routed_s[i];
        end
        sel_s = bus.p2_active ? routed_s[1] : routed_s[0];
        if (!run_s) begin
            game_d = BTN_ZERO;
        end else if (bus.cocktail) begin
            game_d                   = sel_s;
            game_d[BTN_COIN:BTN_S1]  = or_s[BTN_COIN:BTN_S1];
        end else begin
            game_d = or_s;
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (run_s) begin
                joy_d[i*BTN_W +: BTN_W] = routed_s[i];
            end else begin
                joy_d[i*BTN_W +: BTN_W] = BTN_ZERO;
            end
        end
    end

    assign combo_s = (src_s != SRC_USB) && ext_s[DB_START] && ext_s[DB_C];

    always_comb begin
        if (mode_chg_s || !combo_s) begin
            osd_cnt_d = OSD_ZERO;
        end else if (osd_cnt_q == OSD_MAX) begin
            osd_cnt_d = osd_cnt_q;
        end else begin
            osd_cnt_d = osd_cnt_q + OSD_ONE;
        end
        osd_req_d = (osd_cnt_d == OSD_MAX);
    end

    // mode_q loads the live mode under reset so leaving reset does not look like a mode change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
            mode_q       <= bus.joy_mode;
            joy_q        <= {(NUM_PLAYERS*BTN_W){1'b0}};
            game_q       <= BTN_ZERO;
            osd_cnt_q    <= OSD_ZERO;
            osd_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            mode_q       <= bus.joy_mode;
            joy_q        <= joy_d;
            game_q       <= game_d;
            osd_cnt_q    <= osd_cnt_d;
            osd_req_q    <= osd_req_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_coin
        coin_shaper #(
            .COIN_CYC (COIN_CYC)
        ) u_coin (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr_s),
            .coin_in (joy_q[g*BTN_W + BTN_COIN]),
            .pulse   (coin_s[g])
        );
    end

    assign bus.joy        = joy_q;
    assign bus.joy_game   = game_q;
    assign bus.coin_pulse = coin_s;
    assign bus.osd_req    = osd_req_q;

endmodule
